// File: rtl/sram_digital_ctrl_if.sv
// Request/response bus between a master and the SRAM controller.
// Carries the valid/ready request handshake and the read-data return path.
interface sram_digital_ctrl_if #(
  parameter int numRows = 128,
  parameter int numCols = 32
);
  localparam int AW = (numRows > 1) ? $clog2(numRows) : 1;

  logic               rq_wr_i;
  logic               rq_valid_i;
  logic               rq_ready_o;
  logic               rd_valid_o;
  logic [numCols-1:0] rd_data_o;
  logic [numCols-1:0] wr_data_i;
  logic [AW-1:0]      addr_i;

  modport master (
    output rq_wr_i, rq_valid_i, wr_data_i, addr_i,
    input  rq_ready_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  rq_wr_i, rq_valid_i, wr_data_i, addr_i,
    output rq_ready_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/sram_digital_ctrl.sv
// SRAM array sequencer: precharge, wordline activate, then write pulse or sense.
// All array-side controls come straight from flops so the macro sees no glitches.
module sram_digital_ctrl #(
  parameter int numRows = 128,
  parameter int numCols = 32
) (
  input  logic                clk,
  input  logic                nrst,
  sram_digital_ctrl_if.slave  bus,
  output logic [numRows-1:0]  WL,
  output logic                PCH,
  output logic [numCols-1:0]  WR_DATA,
  output logic                WRITE,
  output logic [numCols-1:0]  CSEL,
  output logic                SAEN,
  input  logic [numCols-1:0]  SA_OUT
);
  localparam int AW = (numRows > 1) ? $clog2(numRows) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PRECHARGE,
    ACTIVATE,
    WRITE2,
    SENSE
  } state_t;

  state_t             state;
  logic               wr_q;
  logic [AW-1:0]      addr_q;
  logic [numCols-1:0] data_q;
  logic [numRows-1:0] wl_dec;

  // Out-of-range rows decode to no wordline at all.
  always_comb begin
    wl_dec = '0;
    for (int i = 0; i < numRows; i++) begin
      if (addr_q == AW'(i)) wl_dec[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state          <= IDLE;
      wr_q           <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      bus.rq_ready_o <= 1'b0;
      bus.rd_valid_o <= 1'b0;
      bus.rd_data_o  <= '0;
      WL             <= '0;
      PCH            <= 1'b0;
      WR_DATA        <= '0;
      WRITE          <= 1'b0;
      CSEL           <= '0;
      SAEN           <= 1'b0;
    end else begin
      bus.rd_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.rq_ready_o <= 1'b1;
          if (bus.rq_valid_i && bus.rq_ready_o) begin
            wr_q           <= bus.rq_wr_i;
            addr_q         <= bus.addr_i;
            data_q         <= bus.wr_data_i;
            bus.rq_ready_o <= 1'b0;
            PCH            <= 1'b1;
            state          <= PRECHARGE;
          end
        end
        PRECHARGE: begin
          PCH   <= 1'b0;
          WL    <= wl_dec;
          CSEL  <= '1;
          WRITE <= wr_q;
          if (wr_q) WR_DATA <= data_q;
          state <= ACTIVATE;
        end
        ACTIVATE: begin
          if (wr_q) begin
            state <= WRITE2;
          end else begin
            SAEN  <= 1'b1;
            state <= SENSE;
          end
        end
        WRITE2: begin
          WL             <= '0;
          CSEL           <= '0;
          WRITE          <= 1'b0;
          bus.rq_ready_o <= 1'b1;
          state          <= IDLE;
        end
        SENSE: begin
          WL             <= '0;
          CSEL           <= '0;
          SAEN           <= 1'b0;
          bus.rd_data_o  <= SA_OUT;
          bus.rd_valid_o <= 1'b1;
          bus.rq_ready_o <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_digital_ctrl.sv
// Bench for sram_digital_ctrl: behavioural array model plus a per-address
// reference memory; every transaction is checked cycle by cycle.
module tb_sram_digital_ctrl;
  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [127:0] wl;
  logic         pch;
  logic [31:0]  wr_data;
  logic         wrt;
  logic [31:0]  csel;
  logic         saen;
  logic [31:0]  sa_out;

  int vectors = 0;
  int miscompares = 0;

  sram_digital_ctrl_if #(.numRows(128), .numCols(32)) bus ();

  sram_digital_ctrl #(.numRows(128), .numCols(32)) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus.slave),
    .WL(wl),
    .PCH(pch),
    .WR_DATA(wr_data),
    .WRITE(wrt),
    .CSEL(csel),
    .SAEN(saen),
    .SA_OUT(sa_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_pat(int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Array model: stores on WRITE, drives stored row onto SA_OUT while sensing.
  logic [31:0]  arr [128];
  logic [127:0] arr_written = '0;
  logic [31:0]  noise = 32'h1234_5678;

  always @(posedge clk) begin
    if (wrt) begin
      for (int i = 0; i < 128; i++) begin
        if (wl[i]) begin
          arr[i]         <= wr_data;
          arr_written[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) noise <= $urandom;

  always_comb begin
    sa_out = noise;
    if (saen) begin
      for (int i = 0; i < 128; i++) begin
        if (wl[i]) sa_out = arr_written[i] ? arr[i] : init_pat(i);
      end
    end
  end

  // Reference: what each row should contain, and what rd_data_o should hold.
  logic [31:0] ref_mem [128];
  bit          ref_written [128];
  logic [31:0] exp_rd = '0;

  task automatic do_txn(input bit wr, input logic [6:0] a,
                        input logic [31:0] d, input bit hold);
    logic [164:0] obs, expv;
    logic [127:0] ewl;
    bit           act;
    int           w;
    w = 0;
    while (bus.rq_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    vectors++;
    if (bus.rq_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout got=%b want=1", bus.rq_ready_o);
      return;
    end
    if (hold) begin
      vectors++;
      if (w != 0) begin
        miscompares++;
        $display("FAIL b2b_gap got=%0d want=0 idle cycles", w);
      end
    end
    bus.rq_valid_i = 1'b1;
    bus.rq_wr_i    = wr;
    bus.addr_i     = a;
    bus.wr_data_i  = d;
    ewl = 128'd1 << a;
    if (!wr) exp_rd = ref_written[a] ? ref_mem[a] : init_pat(int'(a));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (!hold && k < 4) begin
        bus.rq_valid_i = (k == 2);
        bus.rq_wr_i    = 1'($urandom);
        bus.addr_i     = 7'($urandom);
        bus.wr_data_i  = $urandom;
      end
      act  = (k == 2) || (k == 3);
      expv = {k == 4, (k == 4) && !wr, k == 1, act && wr,
              (k == 3) && !wr, act ? 32'hFFFF_FFFF : 32'd0,
              act ? ewl : 128'd0};
      obs  = {bus.rq_ready_o, bus.rd_valid_o, pch, wrt, saen, csel, wl};
      vectors++;
      if (obs !== expv) begin
        miscompares++;
        $display("FAIL ctl wr=%0d a=%0d k=%0d got=%h want=%h",
                 wr, a, k, obs, expv);
      end
      vectors++;
      if (!$onehot0(wl) || (pch && |wl)) begin
        miscompares++;
        $display("FAIL wl_excl k=%0d got wl=%h pch=%b want onehot0, no overlap",
                 k, wl, pch);
      end
      if (wr && act) begin
        vectors++;
        if (wr_data !== d) begin
          miscompares++;
          $display("FAIL wr_data k=%0d got=%h want=%h", k, wr_data, d);
        end
      end
      if (k == 4) begin
        vectors++;
        if (bus.rd_data_o !== exp_rd) begin
          miscompares++;
          $display("FAIL rd_data a=%0d got=%h want=%h", a, bus.rd_data_o, exp_rd);
        end
      end
    end
    if (wr) begin
      ref_mem[a]     = d;
      ref_written[a] = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [228:0] obs;
    bus.rq_valid_i = 1'b0;
    bus.rq_wr_i    = 1'b0;
    bus.addr_i     = '0;
    bus.wr_data_i  = '0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    obs = {bus.rq_ready_o, bus.rd_valid_o, pch, wrt, saen, csel, wl,
           wr_data, bus.rd_data_o};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_state got=%h want=0", obs);
    end
    nrst = 1'b1;
    #1;
    vectors++;
    if (bus.rq_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_pre_edge got=%b want=0", bus.rq_ready_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.rq_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_first_edge got=%b want=1", bus.rq_ready_o);
    end
  endtask

  task automatic test_write_read();
    do_txn(1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0);
    do_txn(1'b0, 7'd5, 32'h0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (bus.rd_data_o !== 32'hDEAD_BEEF || bus.rd_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_hold got=%h/%b want=deadbeef/0",
                 bus.rd_data_o, bus.rd_valid_o);
      end
    end
    do_txn(1'b1, 7'd6, 32'h0BAD_F00D, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b1, 7'd0,   32'hA0A0_0000, 1'b1);
    do_txn(1'b0, 7'd127, 32'h0,         1'b1);
    do_txn(1'b1, 7'd127, 32'h7F7F_7F7F, 1'b1);
    do_txn(1'b0, 7'd0,   32'h0,         1'b1);
    do_txn(1'b0, 7'd127, 32'h0,         1'b1);
    bus.rq_valid_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    do_txn(1'b1, 7'd33, 32'h5555_AAAA, 1'b0);
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (pch !== 1'b0 || wl !== '0 || bus.rq_ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL no_extra got pch=%b wl=%h rdy=%b want 0/0/1",
                 pch, wl, bus.rq_ready_o);
      end
    end
    do_txn(1'b0, 7'd33, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [228:0] obs;
    bus.rq_valid_i = 1'b1;
    bus.rq_wr_i    = 1'b0;
    bus.addr_i     = 7'd9;
    @(negedge clk);
    bus.rq_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (saen !== 1'b1 || wl[9] !== 1'b1) begin
      miscompares++;
      $display("FAIL sense_phase got saen=%b wl9=%b want 1/1", saen, wl[9]);
    end
    nrst = 1'b0;
    exp_rd = '0;
    #1;
    obs = {bus.rq_ready_o, bus.rd_valid_o, pch, wrt, saen, csel, wl,
           wr_data, bus.rd_data_o};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL mid_reset got=%h want=0", obs);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.rd_valid_o !== 1'b0 || wl !== '0 || wrt !== 1'b0) begin
        miscompares++;
        $display("FAIL abort got rv=%b wl=%h wr=%b want 0", bus.rd_valid_o, wl, wrt);
      end
    end
    nrst = 1'b1;
    @(negedge clk);
    do_txn(1'b0, 7'd9, 32'h0, 1'b0);
  endtask

  task automatic test_random();
    int gap;
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 7'($urandom_range(0, 15)), $urandom, 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        vectors++;
        if (pch !== 1'b0 || wl !== '0 || bus.rd_valid_o !== 1'b0) begin
          miscompares++;
          $display("FAIL idle got pch=%b wl=%h rv=%b want 0", pch, wl,
                   bus.rd_valid_o);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i]     = '0;
      ref_written[i] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
